// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared funct3 encodings, FSM states, access sizes and lane helpers
package mem_access_unit_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic size_t acc_size(input logic [2:0] f3, input logic ld);
    return (f3 == F3_B || (ld && f3 == F3_BU)) ? SZ_B :
           (f3 == F3_H || (ld && f3 == F3_HU)) ? SZ_H : SZ_W;
  endfunction
  function automatic logic [1:0] lane_off(input size_t sz, input logic [1:0] a);
    return sz == SZ_B ? a : sz == SZ_H ? {a[1], 1'b0} : 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_access_unit_load_align: selects the loaded byte/half lane of rdata at off and sign/zero-extends it (sz, sgn in; data out)
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  size_t       sz,
  input  logic        sgn,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[1], 4'b0000} +: 16];
  assign data = sz == SZ_B ? {{24{sgn & b[7]}}, b} :
                sz == SZ_H ? {{16{sgn & h[15]}}, h} : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM data-memory access unit (EX/MEM *_in controls, dmem_* bus, MEM/WB *_out, stall_out, bus_err_out/misalign_out pulses); MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_en_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_reg_addr_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_en_out,
  output logic [4:0]  rd_reg_addr_out,
  output logic [31:0] data_memory_out,
  output logic [31:0] ALU_result_out,
  output logic        stall_out,
  output logic        bus_err_out,
  output logic        misalign_out
);
  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] r_alu, r_wdata;
  logic [3:0]  r_be;
  logic [4:0]  r_rd;
  size_t       r_sz, sz, c_sz;
  logic        r_we, r_sgn, r_mtr, r_rwe;
  logic        mem_op, mis, busy, tmo, issue, done, stall, v_out;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, c_alu, ld_data;
  assign mem_op   = valid_in & (mem_read_in | mem_write_in);
  assign sz       = acc_size(funct3_in, mem_read_in);
  assign off_in   = lane_off(sz, ALU_result_in[1:0]);
  assign be_in    = mem_read_in ? 4'hF : sz == SZ_B ? 4'b0001 << off_in : sz == SZ_H ? 4'b0011 << off_in : 4'hF;
  assign wdata_in = sz == SZ_B ? {4{store_data_in[7:0]}} : sz == SZ_H ? {2{store_data_in[15:0]}} : store_data_in;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = mem_op & ((sz == SZ_H & ALU_result_in[0]) | (sz == SZ_W & |ALU_result_in[1:0]));
`else
  assign mis = 1'b0;
`endif
  assign busy  = state == BUSY;
  assign tmo   = busy && cnt == 8'(ACK_TIMEOUT);
  // the timeout cycle withdraws the request, so a late ack there is ignored
  assign issue = busy ? !tmo : mem_op & !mis;
  assign done  = issue & dmem_ack;
  assign stall = issue & !dmem_ack;
  assign v_out = (busy | valid_in) & !stall;
  assign c_alu = busy ? r_alu : ALU_result_in;
  assign c_sz  = busy ? r_sz : sz;
  mem_access_unit_load_align u_align (
    .rdata (dmem_rdata),
    .off   (lane_off(c_sz, c_alu[1:0])),
    .sz    (c_sz),
    .sgn   (busy ? r_sgn : !funct3_in[2]),
    .data  (ld_data)
  );
  always_comb begin
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    dmem_addr        = '0;
    dmem_wdata       = '0;
    dmem_be          = '0;
    valid_out        = 1'b0;
    mem_to_reg_out   = 1'b0;
    reg_write_en_out = 1'b0;
    rd_reg_addr_out  = '0;
    data_memory_out  = '0;
    ALU_result_out   = '0;
    stall_out        = 1'b0;
    bus_err_out      = 1'b0;
    misalign_out     = 1'b0;
    if (!rst) begin
      dmem_req         = issue;
      dmem_we          = issue & (busy ? r_we : !mem_read_in);
      dmem_addr        = issue ? {c_alu[31:2], 2'b00} : '0;
      dmem_wdata       = issue ? (busy ? r_wdata : wdata_in) : '0;
      dmem_be          = issue ? (busy ? r_be : be_in) : '0;
      valid_out        = v_out;
      mem_to_reg_out   = busy ? r_mtr : mem_to_reg_in;
      reg_write_en_out = v_out & !tmo & !mis & (busy ? r_rwe : reg_write_en_in);
      rd_reg_addr_out  = busy ? r_rd : rd_reg_addr_in;
      data_memory_out  = done & (busy ? !r_we : mem_read_in) ? ld_data : '0;
      ALU_result_out   = c_alu;
      stall_out        = stall;
      bus_err_out      = tmo;
      misalign_out     = mis;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= '0;
      r_sz    <= SZ_B;
      r_we    <= 1'b0;
      r_sgn   <= 1'b0;
      r_mtr   <= 1'b0;
      r_rwe   <= 1'b0;
    end else if (!busy) begin
      if (stall) begin
        state   <= BUSY;
        cnt     <= 8'd1;
        r_alu   <= ALU_result_in;
        r_wdata <= wdata_in;
        r_be    <= be_in;
        r_rd    <= rd_reg_addr_in;
        r_sz    <= sz;
        r_we    <= !mem_read_in;
        r_sgn   <= !funct3_in[2];
        r_mtr   <= mem_to_reg_in;
        r_rwe   <= reg_write_en_in;
      end
    end else if (stall) begin
      cnt <= cnt + 8'd1;
    end else begin
      state <= IDLE;
      cnt   <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench for mem_access_unit against a byte-lane reference model
module tb_mem_access_unit;
  localparam int T = 15;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_en_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_reg_addr_in;
  logic [31:0] ALU_result_in, store_data_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_out, mem_to_reg_out, reg_write_en_out;
  logic [4:0]  rd_reg_addr_out;
  logic [31:0] data_memory_out, ALU_result_out;
  logic        stall_out, bus_err_out, misalign_out;
  int n_chk = 0;
  int n_err = 0;
  mem_access_unit #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_en_in(reg_write_en_in), .funct3_in(funct3_in),
    .rd_reg_addr_in(rd_reg_addr_in), .ALU_result_in(ALU_result_in), .store_data_in(store_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_out(valid_out), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_en_out(reg_write_en_out), .rd_reg_addr_out(rd_reg_addr_out), .data_memory_out(data_memory_out),
    .ALU_result_out(ALU_result_out), .stall_out(stall_out), .bus_err_out(bus_err_out), .misalign_out(misalign_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int ref_size(input bit ld, input logic [2:0] f3);
    if (ld) return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
  endfunction
  function automatic int ref_off(input int sz, input logic [31:0] a);
    return sz == 1 ? int'(a[1:0]) : sz == 2 ? int'(a[1:0]) & 2 : 0;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] rdat, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = ref_size(1'b1, f3);
    v = rdat >> (8 * ref_off(sz, a));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction
  function automatic logic [3:0] ref_be(input bit ld, input int sz, input int off);
    if (ld || sz == 4) return 4'hF;
    return sz == 1 ? 4'(1 << off) : 4'(3 << off);
  endfunction
  function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] sd);
    return sz == 1 ? 32'(sd[7:0]) * 32'h01010101 : sz == 2 ? 32'(sd[15:0]) * 32'h00010001 : sd;
  endfunction
  task automatic scramble();
    valid_in = 1'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
    mem_to_reg_in = 1'($urandom); reg_write_en_in = 1'($urandom); funct3_in = 3'($urandom);
    rd_reg_addr_in = 5'($urandom); ALU_result_in = $urandom; store_data_in = $urandom;
  endtask
  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    scramble();
    valid_in = 1'b0;
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_err"}, 32'({bus_err_out, misalign_out}), 32'd0);
    chk({tag, "_data"}, data_memory_out, 32'd0);
  endtask
  task automatic alu_op(input string tag);
    logic [31:0] a;
    logic [4:0] rd;
    bit rwe, mtr;
    a = $urandom; rd = 5'($urandom); rwe = 1'($urandom); mtr = 1'($urandom);
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'($urandom);
    ALU_result_in = a; store_data_in = $urandom; rd_reg_addr_in = rd;
    reg_write_en_in = rwe; mem_to_reg_in = mtr;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_rwe"}, 32'(reg_write_en_out), 32'(rwe));
    chk({tag, "_mtr"}, 32'(mem_to_reg_out), 32'(mtr));
    chk({tag, "_rd"}, 32'(rd_reg_addr_out), 32'(rd));
    chk({tag, "_alu"}, ALU_result_out, a);
    chk({tag, "_data"}, data_memory_out, 32'd0);
  endtask
  // delay = stall cycles before the ack; delay >= T means the ack never arrives in time
  task automatic mem_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat, input int delay);
    int sz, off;
    bit mis, is_ld, rwe, mtr;
    logic [4:0] rd;
    is_ld = ld;
    sz = ref_size(is_ld, f3);
    off = ref_off(sz, a);
    rd = 5'($urandom); rwe = 1'($urandom); mtr = 1'($urandom);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`endif
    for (int k = 0; k <= T; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        valid_in = 1'b1; mem_read_in = ld; mem_write_in = st; funct3_in = f3;
        ALU_result_in = a; store_data_in = sd; rd_reg_addr_in = rd;
        mem_to_reg_in = mtr; reg_write_en_in = rwe;
      end else scramble();
      dmem_ack = (k == delay);
      dmem_rdata = dmem_ack ? rdat : $urandom;
      @(negedge clk);
      if (mis) begin
        chk({tag, "_mis_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_mis_pulse"}, 32'(misalign_out), 32'd1);
        chk({tag, "_mis_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_mis_rwe"}, 32'(reg_write_en_out), 32'd0);
        chk({tag, "_mis_stall"}, 32'(stall_out), 32'd0);
        break;
      end
      if (k == T) begin
        chk({tag, "_to_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_to_stall"}, 32'(stall_out), 32'd0);
        chk({tag, "_to_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_to_rwe"}, 32'(reg_write_en_out), 32'd0);
        chk({tag, "_to_err"}, 32'(bus_err_out), 32'd1);
        chk({tag, "_to_alu"}, ALU_result_out, a);
        break;
      end
      chk({tag, "_req"}, 32'(dmem_req), 32'd1);
      chk({tag, "_we"}, 32'(dmem_we), 32'(!is_ld));
      chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      chk({tag, "_be"}, 32'(dmem_be), 32'(ref_be(is_ld, sz, off)));
      if (!is_ld) chk({tag, "_wdata"}, dmem_wdata, ref_wdata(sz, sd));
      chk({tag, "_alu"}, ALU_result_out, a);
      chk({tag, "_err"}, 32'({bus_err_out, misalign_out}), 32'd0);
      if (k < delay) begin
        chk({tag, "_stall"}, 32'(stall_out), 32'd1);
        chk({tag, "_bub_valid"}, 32'(valid_out), 32'd0);
        chk({tag, "_bub_rwe"}, 32'(reg_write_en_out), 32'd0);
      end else begin
        chk({tag, "_done_stall"}, 32'(stall_out), 32'd0);
        chk({tag, "_done_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_done_rwe"}, 32'(reg_write_en_out), 32'(rwe));
        chk({tag, "_done_mtr"}, 32'(mem_to_reg_out), 32'(mtr));
        chk({tag, "_done_rd"}, 32'(rd_reg_addr_out), 32'(rd));
        chk({tag, "_done_data"}, data_memory_out, is_ld ? ref_load(rdat, f3, a) : 32'd0);
        break;
      end
    end
  endtask
  initial begin
    bit ld, st;
    int delay;
    rst = 1'b1;
    scramble();
    valid_in = 1'b1; mem_read_in = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", data_memory_out, 32'd0);
    chk("rst_alu", ALU_result_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle("post_rst");
    mem_op("sw_ack0", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    mem_op("lb_wait3", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00, 3);
    mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1);
    mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0);
    mem_op("sh_hi", 1'b0, 1'b1, 3'b001, 32'h206, 32'h1234CAFE, 32'h0, 2);
    mem_op("ld_st_both", 1'b1, 1'b1, 3'b001, 32'h30, 32'h0, 32'h0000F00D, 0);
    mem_op("undef_f3", 1'b1, 1'b0, 3'b111, 32'h44, 32'h0, 32'h87654321, 0);
    mem_op("timeout", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, 100);
    idle_cycle("after_to");
    mem_op("ack_last", 1'b0, 1'b1, 3'b010, 32'h404, 32'h5A5A5A5A, 32'h0, T - 1);
    mem_op("ack_late", 1'b1, 1'b0, 3'b000, 32'h408, 32'h0, 32'h000000FF, T);
    mem_op("lw_misal", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A5C3C3, 0);
    idle_cycle("after_mis");
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
    ALU_result_in = 32'h500; reg_write_en_in = 1'b1; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    chk("midrst_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("lateack_req", 32'(dmem_req), 32'd0);
    chk("lateack_stall", 32'(stall_out), 32'd0);
    chk("lateack_valid", 32'(valid_out), 32'd0);
    chk("lateack_data", data_memory_out, 32'd0);
    idle_cycle("after_midrst");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) alu_op("rnd_alu");
      else begin
        ld = 1'($urandom);
        st = ld ? 1'($urandom) : 1'b1;
        delay = ($urandom_range(0, 9) == 0) ? T + 2 : $urandom_range(0, 4);
        mem_op("rnd_mem", ld, st, 3'($urandom), $urandom, $urandom, $urandom, delay);
      end
      if ($urandom_range(0, 2) == 0) idle_cycle("rnd_idle");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
